// File: rtl/dror_dispatch_controller.sv
// dror_dispatch_controller: round-robin point dispatcher for DROR validator cores, outlier indices queued in an internal FIFO.
// Latency: start edge enters RUN, first core_load one cycle later; grants are registered, so verdict -> ack takes >= 1 cycle.
// Backpressure: outlier verdicts stall while the FIFO is full (inliers never stall); pause freezes grants, FIFO keeps draining.
// Optional feature macro DISPATCH_STATS_EN adds inlier_count, outlier_count and stall_cycles outputs.
module dror_dispatch_controller #(
    parameter int IDX_W       = 32,
    parameter int CORE_NUMBER = 16,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [IDX_W-1:0]       point_cloud_size,
    input  logic                   pause,
    input  logic [CORE_NUMBER-1:0] core_done,
    input  logic [CORE_NUMBER-1:0] core_outlier,
    output logic [CORE_NUMBER-1:0] core_ack,
    output logic [CORE_NUMBER-1:0] core_load,
    output logic [IDX_W-1:0]       core_point_idx,
    output logic                   out_valid,
    output logic [IDX_W-1:0]       out_idx,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
`ifdef DISPATCH_STATS_EN
    ,
    output logic [IDX_W-1:0]       inlier_count,
    output logic [IDX_W-1:0]       outlier_count,
    output logic [IDX_W-1:0]       stall_cycles
`endif
);
    localparam int CW = (CORE_NUMBER > 1) ? $clog2(CORE_NUMBER) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       size_q, size_d;
    logic [IDX_W-1:0]       next_idx_q, next_idx_d;
    logic [IDX_W-1:0]       retired_q, retired_d;
    logic [CORE_NUMBER-1:0] core_busy_q, core_busy_d;
    logic [IDX_W-1:0]       core_idx_q [CORE_NUMBER];
    logic [IDX_W-1:0]       core_idx_d [CORE_NUMBER];
    logic [CW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [CORE_NUMBER-1:0] ack_q, ack_d;
    logic [CORE_NUMBER-1:0] load_q, load_d;
    logic [IDX_W-1:0]       pidx_q, pidx_d;
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]       fifo_mem_q [FIFO_DEPTH];

    logic                   fifo_full, fifo_empty, pop, push;
    logic [IDX_W-1:0]       push_dat;
    logic [CORE_NUMBER-1:0] cand, pending;
    logic                   grant_vld;
    logic [CW-1:0]          grant_id;
    int                     scan;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign out_valid  = !fifo_empty;
    assign out_idx    = out_valid ? fifo_mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign pop        = out_valid && out_ready;
    // A core whose ack/load pulse is on the wire this cycle still shows its old core_done; skip it.
    assign pending    = ack_q | load_q;

    assign core_ack       = ack_q;
    assign core_load      = load_q;
    assign core_point_idx = pidx_q;
    assign busy           = (state_q == S_RUN);
    assign done           = (state_q == S_DONE);

    // Candidate set: free cores while points remain, finished cores unless an outlier meets a full FIFO.
    always_comb begin
        cand = '0;
        for (int i = 0; i < CORE_NUMBER; i++) begin
            if (core_busy_q[i]) begin
                if (core_done[i] && !pending[i] && !(core_outlier[i] && fifo_full)) begin
                    cand[i] = 1'b1;
                end
            end else if (next_idx_q < size_q) begin
                cand[i] = 1'b1;
            end
        end
        if (state_q != S_RUN || pause) begin
            cand = '0;
        end
    end

    // Round-robin pick: first candidate at or after the pointer.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan      = 0;
        for (int k = 0; k < CORE_NUMBER; k++) begin
            scan = int'(rr_ptr_q) + k;
            if (scan >= CORE_NUMBER) begin
                scan = scan - CORE_NUMBER;
            end
            if (!grant_vld && cand[scan]) begin
                grant_vld = 1'b1;
                grant_id  = CW'(scan);
            end
        end
    end

    // Run sequencing and grant side effects: retire verdict, reload or free the core.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        next_idx_d  = next_idx_q;
        retired_d   = retired_q;
        core_busy_d = core_busy_q;
        core_idx_d  = core_idx_q;
        rr_ptr_d    = rr_ptr_q;
        ack_d       = '0;
        load_d      = '0;
        pidx_d      = pidx_q;
        push        = 1'b0;
        push_dat    = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RUN;
                    size_d     = point_cloud_size;
                    next_idx_d = '0;
                    retired_d  = '0;
                end
            end
            S_RUN: begin
                if (retired_q == size_q) begin
                    state_d = S_DONE;
                end else if (grant_vld) begin
                    if (core_busy_q[grant_id]) begin
                        ack_d[grant_id] = 1'b1;
                        retired_d       = retired_q + 1'b1;
                        if (core_outlier[grant_id]) begin
                            push     = 1'b1;
                            push_dat = core_idx_q[grant_id];
                        end
                    end
                    if (next_idx_q < size_q) begin
                        load_d[grant_id]      = 1'b1;
                        pidx_d                = next_idx_q;
                        core_idx_d[grant_id]  = next_idx_q;
                        core_busy_d[grant_id] = 1'b1;
                        next_idx_d            = next_idx_q + 1'b1;
                    end else begin
                        core_busy_d[grant_id] = 1'b0;
                    end
                    rr_ptr_d = (int'(grant_id) == CORE_NUMBER - 1) ? '0 : grant_id + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // Controller state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            size_q      <= '0;
            next_idx_q  <= '0;
            retired_q   <= '0;
            core_busy_q <= '0;
            for (int i = 0; i < CORE_NUMBER; i++) begin
                core_idx_q[i] <= '0;
            end
            rr_ptr_q    <= '0;
            ack_q       <= '0;
            load_q      <= '0;
            pidx_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            next_idx_q  <= next_idx_d;
            retired_q   <= retired_d;
            core_busy_q <= core_busy_d;
            core_idx_q  <= core_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            ack_q       <= ack_d;
            load_q      <= load_d;
            pidx_q      <= pidx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Outlier FIFO storage, written at the tail on push.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [IDX_W-1:0]       inl_q, inl_d, outl_q, outl_d, stall_q, stall_d;
    logic [CORE_NUMBER-1:0] blocked;

    // Verdict and stall counters, cleared on each accepted start.
    always_comb begin
        inl_d   = inl_q;
        outl_d  = outl_q;
        stall_d = stall_q;
        blocked = core_busy_q & core_done & core_outlier & ~pending & {CORE_NUMBER{fifo_full}};
        if (state_q != S_RUN && start) begin
            inl_d   = '0;
            outl_d  = '0;
            stall_d = '0;
        end else begin
            if (|(ack_d & ~core_outlier)) inl_d = inl_q + 1'b1;
            if (|(ack_d & core_outlier))  outl_d = outl_q + 1'b1;
            if (state_q == S_RUN && |blocked) stall_d = stall_q + 1'b1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inl_q   <= '0;
            outl_q  <= '0;
            stall_q <= '0;
        end else begin
            inl_q   <= inl_d;
            outl_q  <= outl_d;
            stall_q <= stall_d;
        end
    end

    assign inlier_count  = inl_q;
    assign outlier_count = outl_q;
    assign stall_cycles  = stall_q;
`endif

endmodule

// File: tb/tb_dror_dispatch_controller.sv
// tb_dror_dispatch_controller: directed runs against behavioural validator cores, scoreboarded load/outlier streams.
// Latency: cores raise core_done 3 cycles after a load and hold it until acked.
// Backpressure: out_ready driven by the stimulus to exercise FIFO stalls and draining.
module tb_dror_dispatch_controller;
    localparam int IDX_W = 32;
    localparam int NC    = 4;
    localparam int FD    = 2;
    localparam int LAT   = 3;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic             out_ready = 1'b0;
    logic [IDX_W-1:0] point_cloud_size = '0;
    logic [NC-1:0]    core_done = '0;
    logic [NC-1:0]    core_outlier = '0;
    logic [NC-1:0]    core_ack, core_load;
    logic [IDX_W-1:0] core_point_idx, out_idx;
    logic             out_valid, busy, done;

    int               n_checks = 0;
    int               n_pass = 0;
    logic [IDX_W-1:0] exp_out_q[$];
    logic [IDX_W-1:0] exp_load_q[$];
    bit               otbl[64];
    int               load_seen[64];
    int               load_core[64];
    int               ack_total = 0;
    int               load_total = 0;

    dror_dispatch_controller #(.IDX_W(IDX_W), .CORE_NUMBER(NC), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .point_cloud_size(point_cloud_size),
        .pause(pause), .core_done(core_done), .core_outlier(core_outlier), .core_ack(core_ack),
        .core_load(core_load), .core_point_idx(core_point_idx), .out_valid(out_valid),
        .out_idx(out_idx), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run_start(input int size);
        @(negedge clock);
        point_cloud_size = IDX_W'(size);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int k;
        k = 0;
        while (!done && k < bound) begin
            @(negedge clock);
            k++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic push_loads(input int n);
        for (int k = 0; k < n; k++) exp_load_q.push_back(IDX_W'(k));
    endtask

    // Behavioural validator cores: react at the falling edge to pulses set at the rising edge.
    initial begin
        int unsigned      cnt[NC];
        logic [IDX_W-1:0] cidx[NC];
        logic [NC-1:0]    cdone, cout;
        cdone = '0;
        cout  = '0;
        for (int i = 0; i < NC; i++) begin
            cnt[i]  = 0;
            cidx[i] = '0;
        end
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                cdone = '0;
                cout  = '0;
                for (int i = 0; i < NC; i++) cnt[i] = 0;
            end else begin
                for (int i = 0; i < NC; i++) begin
                    if (core_ack[i]) begin
                        ack_total++;
                        cdone[i] = 1'b0;
                    end
                    if (core_load[i]) begin
                        load_total++;
                        cidx[i]  = core_point_idx;
                        cnt[i]   = LAT;
                        cdone[i] = 1'b0;
                        if (core_point_idx < 64) begin
                            load_seen[core_point_idx[5:0]]++;
                            load_core[core_point_idx[5:0]] = i;
                        end
                    end else if (cnt[i] != 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            cdone[i] = 1'b1;
                            cout[i]  = (cidx[i] < 64) ? otbl[cidx[i][5:0]] : 1'b0;
                        end
                    end
                end
            end
            core_done    = cdone;
            core_outlier = cout;
        end
    end

    // Monitor: pops the scoreboards whenever the DUT presents a load or an accepted output.
    initial begin
        logic [IDX_W-1:0] e;
        forever begin
            @(negedge clock);
            #1;
            if (reset_n) begin
                if (core_load != '0) begin
                    check("load_onehot", {31'd0, $onehot(core_load)}, 32'd1);
                    if (exp_load_q.size() > 0) begin
                        e = exp_load_q.pop_front();
                        check("load_idx", core_point_idx, e);
                    end else begin
                        n_checks++;
                        $display("FAIL load_extra: got idx %0d expected no load", core_point_idx);
                    end
                end
                if (core_ack != '0) check("ack_onehot", {31'd0, $onehot(core_ack)}, 32'd1);
                if (out_valid && out_ready) begin
                    if (exp_out_q.size() > 0) begin
                        e = exp_out_q.pop_front();
                        check("out_idx", out_idx, e);
                    end else begin
                        n_checks++;
                        $display("FAIL out_extra: got idx %0d expected empty", out_idx);
                    end
                end
            end
        end
    end

    initial begin
        #40000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int a0, l0, uniq;
        for (int k = 0; k < 64; k++) begin
            otbl[k] = 1'b0;
            load_seen[k] = 0;
            load_core[k] = -1;
        end
        #2;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_load", {28'd0, core_load}, 0);
        check("rst_ack", {28'd0, core_ack}, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // size 4, all inliers: loads 0..3 land on cores 0..3
        push_loads(4);
        a0 = ack_total;
        run_start(4);
        wait_done("t1_done", 40);
        for (int k = 0; k < 4; k++) check("t1_core_of_idx", load_core[k], k);
        check("t1_acks", ack_total - a0, 4);
        check("t1_out_valid", {31'd0, out_valid}, 0);
        check("t1_loads_seen", exp_load_q.size(), 0);

        // size 10, outliers at 2,5,9 come out in order
        otbl[2] = 1'b1; otbl[5] = 1'b1; otbl[9] = 1'b1;
        out_ready = 1'b1;
        exp_out_q.push_back(2); exp_out_q.push_back(5); exp_out_q.push_back(9);
        push_loads(10);
        a0 = ack_total; l0 = load_total;
        run_start(10);
        wait_done("t2_done", 60);
        repeat (4) @(negedge clock);
        check("t2_outs_seen", exp_out_q.size(), 0);
        check("t2_out_valid", {31'd0, out_valid}, 0);
        check("t2_acks", ack_total - a0, 10);
        check("t2_loads", load_total - l0, 10);

        // all outliers, FIFO of 2 with no drain: stall after two acks, then drain everything
        for (int k = 0; k < 8; k++) otbl[k] = 1'b1;
        out_ready = 1'b0;
        push_loads(8);
        a0 = ack_total;
        run_start(8);
        repeat (25) @(negedge clock);
        check("t3_stall_acks", ack_total - a0, 2);
        check("t3_stall_valid", {31'd0, out_valid}, 1);
        check("t3_stall_head", out_idx, 0);
        check("t3_stall_done", {31'd0, done}, 0);
        for (int k = 0; k < 8; k++) exp_out_q.push_back(IDX_W'(k));
        out_ready = 1'b1;
        wait_done("t3_done", 100);
        repeat (6) @(negedge clock);
        check("t3_outs_seen", exp_out_q.size(), 0);
        check("t3_out_valid", {31'd0, out_valid}, 0);
        check("t3_acks", ack_total - a0, 8);

        // pause for 5 cycles mid-run: no pulses, verdicts stay pending, indices unique
        for (int k = 0; k < 64; k++) begin
            otbl[k] = 1'b0;
            load_seen[k] = 0;
        end
        push_loads(8);
        run_start(8);
        repeat (5) @(negedge clock);
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("t4_pause_ack", {28'd0, core_ack}, 0);
            check("t4_pause_load", {28'd0, core_load}, 0);
        end
        check("t4_pending", {31'd0, |core_done}, 1);
        pause = 1'b0;
        wait_done("t4_done", 60);
        uniq = 0;
        for (int k = 0; k < 8; k++) if (load_seen[k] == 1) uniq++;
        check("t4_unique_idx", uniq, 8);

        // size 0: one RUN cycle, then DONE, no loads
        l0 = load_total;
        run_start(0);
        check("t5_busy", {31'd0, busy}, 1);
        check("t5_done_low", {31'd0, done}, 0);
        @(negedge clock);
        check("t5_done", {31'd0, done}, 1);
        check("t5_loads", load_total - l0, 0);

        // reset mid-run with one queued outlier, then a clean run
        otbl[0] = 1'b1;
        out_ready = 1'b0;
        push_loads(8);
        run_start(8);
        repeat (7) @(negedge clock);
        check("t6_pre_valid", {31'd0, out_valid}, 1);
        check("t6_pre_busy", {31'd0, busy}, 1);
        #3 reset_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, out_valid}, 0);
        check("t6_rst_busy", {31'd0, busy}, 0);
        check("t6_rst_done", {31'd0, done}, 0);
        check("t6_rst_load", {28'd0, core_load}, 0);
        check("t6_rst_ack", {28'd0, core_ack}, 0);
        check("t6_rst_out_idx", out_idx, 0);
        check("t6_rst_pidx", core_point_idx, 0);
        @(negedge clock);
        exp_load_q.delete();
        otbl[0] = 1'b0;
        #3 reset_n = 1'b1;
        out_ready = 1'b1;
        push_loads(4);
        a0 = ack_total;
        run_start(4);
        wait_done("t6_done", 40);
        repeat (4) @(negedge clock);
        check("t6_out_valid", {31'd0, out_valid}, 0);
        check("t6_acks", ack_total - a0, 4);
        check("t6_loads_seen", exp_load_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
